sfx_scheduler: RTL and testbench
================================

// Module: sfx_scheduler
// PURPOSE
//  Shares the single APU sound voice between the three SFX requesters: eat, hit, die.
//  Latches one-cycle request pulses from the SFX trigger logic as pending requests.
//  Grants the voice at frame boundaries by fixed priority (die > hit > eat).
//  Times each sound in frames and drives the voice select/start into the APU voice.
// PARAMETERS
//  CNT_W       6   width of frame counter
//  EAT_FRAMES  8   eat sound length in frames (legal 1..2^CNT_W-1)
//  HIT_FRAMES  12  hit sound length in frames (legal 1..2^CNT_W-1)
//  DIE_FRAMES  30  die sound length in frames (legal 1..2^CNT_W-1)
// PORTS
//  clk             in   1      system clock
//  reset           in   1      asynchronous, active-low reset (0 = reset)
//  frame_end       in   1      1-cycle pulse, end of video frame
//  eat_req         in   1      1-cycle request pulse, eat sound
//  hit_req         in   1      1-cycle request pulse, hit sound
//  die_req         in   1      1-cycle request pulse, die sound
//  sfx_start       out  1      1-cycle pulse: voice (re)starts sound on sfx_sel
//  sfx_sel         out  2      0=none, 1=eat, 2=hit, 3=die; stable while playing
//  sfx_active      out  1      1 while a sound owns the voice
//  sfx_frames_left out  CNT_W  frames remaining incl. current, 0 when idle
//  sfx_preempt     out  1      1-cycle pulse: playing sound cut by higher priority
// BEHAVIOUR
//  Reset (reset=0, async):
//   - All outputs, pending bits and counter go to 0; state IDLE.
//   - Takes effect immediately, even mid-sound; no start pulse on release.
//  Pending:
//   - pending[k] is set on its req pulse and held until granted.
//   - Repeat reqs while pending merge into one.
//   - A req in the same cycle as its own grant is absorbed; pending ends 0.
//  Decisions are made only in cycles with frame_end=1.
//   - All outputs are registered and update on that clock edge, visible the next cycle.
//   - Latency from frame_end to sfx_start is 1 cycle.
//   - A req coinciding with frame_end is included in that decision.
//  FSM IDLE (sfx_sel=0, sfx_active=0, frames_left=0), on frame_end:
//   - any pending -> grant highest k; sfx_sel=k, frames_left=K_FRAMES;
//   - also sfx_start=1, sfx_active=1; clear pending[k]; go to PLAY.
//   - no pending -> stay IDLE.
//  FSM PLAY, on frame_end, in priority order:
//   a) Pending with priority strictly above sfx_sel -> preempt:
//      - grant it and reload frames_left; sfx_start=1, sfx_preempt=1;
//      - the cut sound is dropped, not re-queued.
//   b) Else if frames_left==1 and any pending -> back-to-back:
//      - grant highest pending; sfx_start=1, no gap frame.
//   c) Else if frames_left==1 -> go to IDLE; sfx_sel=0, sfx_active=0, frames_left=0.
//   d) Else -> frames_left decrements by 1.
//  Priority rules:
//   - Same-sound or lower-priority pending never preempts.
//   - It waits for rule (b).
//  Counter:
//   - Unsigned CNT_W bits; never wraps.
//   - Parameter value 0 is illegal (checked by an assertion in simulation).
//  Pulse outputs:
//   - sfx_start and sfx_preempt are high exactly 1 cycle.
//   - Both are 0 in every cycle without a grant.
// TESTING
//  1 Reset: hold reset=0 5 cycles with reqs toggling -> all outputs 0, no start after release.
//  2 Basic:
//    - Stimulus: eat_req, then frame_end.
//    - Next cycle: sfx_start=1, sfx_sel=1, frames_left=8.
//    - After 8 frame_ends: sfx_sel=0, sfx_active=0.
//  3 Priority: eat_req+die_req same cycle, then frame_end -> sfx_sel=3 for 30 frames.
//    Then eat plays back-to-back with sfx_start=1 and no idle frame.
//  4 Preempt:
//    - Stimulus: hit playing with frames_left=5, then die_req + frame_end.
//    - Required: sfx_sel=3, frames_left=30, sfx_preempt=1 for 1 cycle.
//    - The hit sound never resumes.
//  5 Merge/no-preempt: during die, 3 hit_reqs and a die_req.
//    -> No preempt. After die ends: die replays once, then hit plays once.
//  6 Async reset mid-PLAY (frames_left=17): reset=0 between clk edges.
//    -> Outputs 0 immediately; pending cleared.

Source files
------------

// File: rtl/sfx_scheduler.sv
// Shares the single APU sound voice between eat, hit and die requesters.
// Latches request pulses, grants by fixed priority at frame boundaries and times each sound in frames.
//
// state | meaning
// IDLE  | voice free, sfx_sel=0, waiting for a pending request at frame_end
// PLAY  | voice owned by sfx_sel, frames_left counting down at each frame_end
module sfx_scheduler #(
    parameter int unsigned CNT_W      = 6,
    parameter int unsigned EAT_FRAMES = 8,
    parameter int unsigned HIT_FRAMES = 12,
    parameter int unsigned DIE_FRAMES = 30
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             frame_end_i,
    input  logic             eat_req_i,
    input  logic             hit_req_i,
    input  logic             die_req_i,
    output logic             sfx_start_o,
    output logic [1:0]       sfx_sel_o,
    output logic             sfx_active_o,
    output logic [CNT_W-1:0] sfx_frames_left_o,
    output logic             sfx_preempt_o
);

    localparam logic [0:0]  ST_IDLE    = 1'b0;
    localparam logic [0:0]  ST_PLAY    = 1'b1;
    localparam int unsigned MAX_FRAMES = (1 << CNT_W) - 1;

    logic [0:0]       state_q, state_d;
    logic [2:0]       pending_q, pending_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] left_q, left_d;
    logic             start_q, start_d;
    logic             preempt_q, preempt_d;

    logic [2:0]       pend_all;
    logic [1:0]       top;
    logic [2:0]       top_mask;

    function automatic logic [CNT_W-1:0] frames_of(input logic [1:0] sel);
        case (sel)
            2'd1:    frames_of = EAT_FRAMES[CNT_W-1:0];
            2'd2:    frames_of = HIT_FRAMES[CNT_W-1:0];
            2'd3:    frames_of = DIE_FRAMES[CNT_W-1:0];
            default: frames_of = '0;
        endcase
    endfunction

    // Bit 0 = eat, 1 = hit, 2 = die; a request arriving this cycle joins the decision.
    always_comb begin
        pend_all = pending_q | {die_req_i, hit_req_i, eat_req_i};
        if (pend_all[2])      top = 2'd3;
        else if (pend_all[1]) top = 2'd2;
        else if (pend_all[0]) top = 2'd1;
        else                  top = 2'd0;
        case (top)
            2'd1:    top_mask = 3'b001;
            2'd2:    top_mask = 3'b010;
            2'd3:    top_mask = 3'b100;
            default: top_mask = 3'b000;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pend_all;
        sel_d     = sel_q;
        left_d    = left_q;
        start_d   = 1'b0;
        preempt_d = 1'b0;
        if (frame_end_i) begin
            if ((state_q == ST_IDLE && top != 2'd0) ||
                (state_q == ST_PLAY && (top > sel_q || (left_q == 1 && top != 2'd0)))) begin
                state_d   = ST_PLAY;
                sel_d     = top;
                left_d    = frames_of(top);
                start_d   = 1'b1;
                preempt_d = (state_q == ST_PLAY) && (top > sel_q);
                pending_d = pend_all & ~top_mask;
            end else if (state_q == ST_PLAY) begin
                if (left_q > 1) begin
                    left_d = left_q - 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    sel_d   = 2'd0;
                    left_d  = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            sel_q     <= '0;
            left_q    <= '0;
            start_q   <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            sel_q     <= sel_d;
            left_q    <= left_d;
            start_q   <= start_d;
            preempt_q <= preempt_d;
        end
    end

    assign sfx_start_o       = start_q;
    assign sfx_sel_o         = sel_q;
    assign sfx_active_o      = (state_q == ST_PLAY);
    assign sfx_frames_left_o = left_q;
    assign sfx_preempt_o     = preempt_q;

    a_frames_legal: assert property (@(posedge clk_i)
        EAT_FRAMES != 0 && EAT_FRAMES <= MAX_FRAMES &&
        HIT_FRAMES != 0 && HIT_FRAMES <= MAX_FRAMES &&
        DIE_FRAMES != 0 && DIE_FRAMES <= MAX_FRAMES);

endmodule

// File: tb/tb_sfx_scheduler.sv
// Directed bench for sfx_scheduler: vector table for the first sequence,
// hand-written sequences for long plays, preemption, merging and async reset.
module tb_sfx_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fe = 1'b0, eat = 1'b0, hit = 1'b0, die = 1'b0;
    logic       start, active, preempt;
    logic [1:0] sel;
    logic [5:0] left;

    int checks = 0;
    int errors = 0;

    sfx_scheduler dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .frame_end_i       (fe),
        .eat_req_i         (eat),
        .hit_req_i         (hit),
        .die_req_i         (die),
        .sfx_start_o       (start),
        .sfx_sel_o         (sel),
        .sfx_active_o      (active),
        .sfx_frames_left_o (left),
        .sfx_preempt_o     (preempt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       fe, eat, hit, die;
        logic       st;
        logic [1:0] sel;
        logic       act;
        logic [5:0] left;
        logic       pre;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic e_st, input logic [1:0] e_sel,
                       input logic e_act, input logic [5:0] e_left, input logic e_pre);
        checks++;
        if ({start, sel, active, left, preempt} !== {e_st, e_sel, e_act, e_left, e_pre}) begin
            errors++;
            $display("FAIL %s: got start=%0b sel=%0d active=%0b left=%0d preempt=%0b, want start=%0b sel=%0d active=%0b left=%0d preempt=%0b",
                     name, start, sel, active, left, preempt, e_st, e_sel, e_act, e_left, e_pre);
        end
    endtask

    // One clock: drive inputs, take the edge, drop the pulses, leave 1 time unit for sampling.
    task automatic cyc(input logic f, input logic e, input logic h, input logic d);
        fe = f; eat = e; hit = h; die = d;
        @(posedge clk);
        #1;
        fe = 1'b0; eat = 1'b0; hit = 1'b0; die = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        //            fe eat hit die  st sel act left pre
        tbl[0] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,2'd0,1'b0,6'd0, 1'b0};
        tbl[1] = '{1'b0,1'b1,1'b0,1'b0, 1'b0,2'd0,1'b0,6'd0, 1'b0};
        tbl[2] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,2'd1,1'b1,6'd8, 1'b0};
        tbl[3] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,2'd1,1'b1,6'd8, 1'b0};
        tbl[4] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,2'd1,1'b1,6'd7, 1'b0};
        tbl[5] = '{1'b0,1'b0,1'b1,1'b0, 1'b0,2'd1,1'b1,6'd7, 1'b0};
        tbl[6] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,2'd2,1'b1,6'd12,1'b1};
        tbl[7] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,2'd2,1'b1,6'd12,1'b0};
        tbl[8] = '{1'b1,1'b1,1'b0,1'b0, 1'b0,2'd2,1'b1,6'd11,1'b0};
        tbl[9] = '{1'b1,1'b1,1'b0,1'b1, 1'b1,2'd3,1'b1,6'd30,1'b1};

        // Reset held 5 cycles with requests and frame_end toggling.
        for (int i = 0; i < 5; i++) begin
            cyc(i[0], 1'b1, i[1], ~i[0]);
            chk("reset_hold", 1'b0, 2'd0, 1'b0, 6'd0, 1'b0);
        end
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_release", 1'b0, 2'd0, 1'b0, 6'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_no_start", 1'b0, 2'd0, 1'b0, 6'd0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].fe, tbl[i].eat, tbl[i].hit, tbl[i].die);
            chk($sformatf("vec%0d", i), tbl[i].st, tbl[i].sel, tbl[i].act, tbl[i].left, tbl[i].pre);
        end

        // Die runs down to its last frame, then the pending eat follows with no gap.
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("die_pulse_clear", 1'b0, 2'd3, 1'b1, 6'd30, 1'b0);
        frames(29);
        chk("die_last_frame", 1'b0, 2'd3, 1'b1, 6'd1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("b2b_eat", 1'b1, 2'd1, 1'b1, 6'd8, 1'b0);
        frames(7);
        chk("eat_last_frame", 1'b0, 2'd1, 1'b1, 6'd1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("eat_to_idle", 1'b0, 2'd0, 1'b0, 6'd0, 1'b0);

        // Request in the same cycle as its own grant is absorbed: no replay.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("basic_grant", 1'b1, 2'd1, 1'b1, 6'd8, 1'b0);
        frames(8);
        chk("basic_8_frames", 1'b0, 2'd0, 1'b0, 6'd0, 1'b0);
        frames(2);
        chk("absorb_no_replay", 1'b0, 2'd0, 1'b0, 6'd0, 1'b0);

        // Hit at frames_left=5 cut by die; hit never resumes.
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("hit_grant", 1'b1, 2'd2, 1'b1, 6'd12, 1'b0);
        frames(7);
        chk("hit_at_5", 1'b0, 2'd2, 1'b1, 6'd5, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("preempt_die", 1'b1, 2'd3, 1'b1, 6'd30, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("preempt_one_cycle", 1'b0, 2'd3, 1'b1, 6'd30, 1'b0);

        // During die: repeated hit reqs merge, die req waits; neither preempts.
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("no_preempt_same_lower", 1'b0, 2'd3, 1'b1, 6'd29, 1'b0);
        frames(28);
        chk("die1_last", 1'b0, 2'd3, 1'b1, 6'd1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("die_replay", 1'b1, 2'd3, 1'b1, 6'd30, 1'b0);
        frames(29);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("hit_after_die", 1'b1, 2'd2, 1'b1, 6'd12, 1'b0);
        frames(12);
        chk("hit_once_idle", 1'b0, 2'd0, 1'b0, 6'd0, 1'b0);
        frames(2);
        chk("merge_no_repeat", 1'b0, 2'd0, 1'b0, 6'd0, 1'b0);

        // Async reset between edges mid-play at frames_left=17, with eat pending.
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        frames(13);
        chk("die_at_17", 1'b0, 2'd3, 1'b1, 6'd17, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_now", 1'b0, 2'd0, 1'b0, 6'd0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        frames(2);
        chk("pending_cleared", 1'b0, 2'd0, 1'b0, 6'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
